// File: rtl/idelay_sweep_pkg.sv
// Shared types and constants for the IDELAY tap sweep controller.
package idelay_sweep_pkg;

   localparam int NTAPS = 32;
   localparam int TAP_W = 5;
   // Timer width: the measure span is WINDOW_CYCLES+3, so it can exceed 16 bits
   localparam int TMR_W = 17;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_MEASURE,
      S_REPORT,
      S_FINISH
   } state_e;

endpackage

// File: rtl/sweep_timer.sv
// Loadable down-counter with a terminal-count flag, shared by SETTLE and MEASURE.
// tc is high during the last cycle of a loaded span (count == 1).
module sweep_timer
   import idelay_sweep_pkg::*;
#(
   parameter int W = TMR_W
) (
   input  logic         gclk,
   input  logic         grst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   // Reload on request, otherwise count down and park at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   // Counter register
   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign tc  = (cnt_q == W'(1));
   assign cnt = cnt_q;

endmodule

// File: rtl/idelay_sweep_controller.sv
// Sweeps all 32 IDELAY taps, measuring the error count at each and streaming
// {tap, count} results over a valid/ready handshake.
// Optional macro IDELAY_SWEEP_BEST_TAP_EN adds BEST_TAP/BEST_CNT tracking.
module idelay_sweep_controller
   import idelay_sweep_pkg::*;
#(
   parameter int WINDOW_CYCLES = 1024,
   parameter int SETTLE_CYCLES = 8,
   parameter int CNT_W         = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             CAL_RDY,
   input  logic             START,
   output logic             BUSY,
   output logic             DONE,
   output logic             ABORT,
   output logic [TAP_W-1:0] DELAY,
   output logic             DLY_LD,
   output logic             ERR_CLR,
   output logic             ERR_EN,
   input  logic [CNT_W-1:0] ERR_CNT,
   output logic             RES_VALID,
   input  logic             RES_READY,
   output logic [TAP_W-1:0] RES_TAP,
   output logic [CNT_W-1:0] RES_CNT
`ifdef IDELAY_SWEEP_BEST_TAP_EN
   ,
   output logic [TAP_W-1:0] BEST_TAP,
   output logic [CNT_W-1:0] BEST_CNT
`endif
);

   // MEASURE span: 1 clear cycle + WINDOW enable cycles + 2 drain cycles
   localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES);
   localparam logic [TMR_W-1:0] MEAS_LOAD   = TMR_W'(WINDOW_CYCLES + 3);
   localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(NTAPS - 1);

   state_e             state_q, state_d;
   logic [TAP_W-1:0]   tap_q, tap_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               abort_q, abort_d;
   logic               dly_ld_q, dly_ld_d;
   logic               err_clr_q, err_clr_d;
   logic               err_en_q, err_en_d;
   logic               res_valid_q, res_valid_d;
   logic [TAP_W-1:0]   res_tap_q, res_tap_d;
   logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;

   logic               tmr_load, tmr_tc;
   logic [TMR_W-1:0]   tmr_val, tmr_cnt;

   sweep_timer #(.W(TMR_W)) u_timer (
      .gclk     (CLK),
      .grst_n   (RST_N),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tmr_tc),
      .cnt      (tmr_cnt)
   );

   // Next-state and next-output logic; outputs are computed for the cycle being entered
   always_comb begin
      state_d     = state_q;
      tap_d       = tap_q;
      done_d      = 1'b0;
      abort_d     = 1'b0;
      dly_ld_d    = 1'b0;
      err_clr_d   = 1'b0;
      err_en_d    = 1'b0;
      res_valid_d = res_valid_q;
      res_tap_d   = res_tap_q;
      res_cnt_d   = res_cnt_q;
      tmr_load    = 1'b0;
      tmr_val     = '0;
      if (state_q != S_IDLE && !CAL_RDY) begin
         // Calibration lost: drop everything, including a pending result
         state_d     = S_IDLE;
         abort_d     = 1'b1;
         res_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: if (START && CAL_RDY) begin
               state_d  = S_LOAD;
               tap_d    = '0;
               dly_ld_d = 1'b1;
            end
            S_LOAD: begin
               state_d  = S_SETTLE;
               tmr_load = 1'b1;
               tmr_val  = SETTLE_LOAD;
            end
            S_SETTLE: if (tmr_tc) begin
               state_d   = S_MEASURE;
               tmr_load  = 1'b1;
               tmr_val   = MEAS_LOAD;
               err_clr_d = 1'b1;
            end
            S_MEASURE: begin
               // Enable while the next count lands in [3, WINDOW+2]; counts 2 and 1 drain the counter pipe
               err_en_d = (tmr_cnt >= TMR_W'(4));
               if (tmr_tc) begin
                  state_d     = S_REPORT;
                  res_valid_d = 1'b1;
                  res_tap_d   = tap_q;
                  res_cnt_d   = ERR_CNT;
               end
            end
            S_REPORT: if (RES_READY) begin
               res_valid_d = 1'b0;
               if (tap_q != LAST_TAP) begin
                  state_d  = S_LOAD;
                  tap_d    = tap_q + TAP_W'(1);
                  dly_ld_d = 1'b1;
               end else begin
                  state_d = S_FINISH;
                  done_d  = 1'b1;
               end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
      busy_d = (state_d != S_IDLE);
   end

   // State and registered outputs
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         tap_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         abort_q     <= 1'b0;
         dly_ld_q    <= 1'b0;
         err_clr_q   <= 1'b0;
         err_en_q    <= 1'b0;
         res_valid_q <= 1'b0;
         res_tap_q   <= '0;
         res_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         tap_q       <= tap_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         abort_q     <= abort_d;
         dly_ld_q    <= dly_ld_d;
         err_clr_q   <= err_clr_d;
         err_en_q    <= err_en_d;
         res_valid_q <= res_valid_d;
         res_tap_q   <= res_tap_d;
         res_cnt_q   <= res_cnt_d;
      end
   end

   // tap only changes on LOAD entry, so it doubles as the DELAY register
   assign DELAY     = tap_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign ABORT     = abort_q;
   assign DLY_LD    = dly_ld_q;
   assign ERR_CLR   = err_clr_q;
   assign ERR_EN    = err_en_q;
   assign RES_VALID = res_valid_q;
   assign RES_TAP   = res_tap_q;
   assign RES_CNT   = res_cnt_q;

`ifdef IDELAY_SWEEP_BEST_TAP_EN
   logic [TAP_W-1:0] best_tap_q, best_tap_d;
   logic [CNT_W-1:0] best_cnt_q, best_cnt_d;

   // Track the lowest count; strict compare keeps the earliest tap on ties
   always_comb begin
      best_tap_d = best_tap_q;
      best_cnt_d = best_cnt_q;
      if (state_q == S_IDLE && state_d == S_LOAD) begin
         best_tap_d = '0;
         best_cnt_d = '1;
      end else if (state_q == S_MEASURE && state_d == S_REPORT && ERR_CNT < best_cnt_q) begin
         best_tap_d = tap_q;
         best_cnt_d = ERR_CNT;
      end
   end

   // Best-tap registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         best_tap_q <= '0;
         best_cnt_q <= '0;
      end else begin
         best_tap_q <= best_tap_d;
         best_cnt_q <= best_cnt_d;
      end
   end

   assign BEST_TAP = best_tap_q;
   assign BEST_CNT = best_cnt_q;
`else
   // Best-tap tracking not built in this configuration
`endif

endmodule

// File: tb/tb_idelay_sweep_controller.sv
// Directed bench for idelay_sweep_controller (WINDOW=16, SETTLE=4).
module tb_idelay_sweep_controller;

   localparam int WIN    = 16;
   localparam int SET    = 4;
   localparam int TAPCYC = 1 + SET + 1 + WIN + 2 + 1;
   localparam int SWEEP  = 32 * TAPCYC + 1;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        CAL_RDY = 1'b0;
   logic        START = 1'b0;
   logic        RES_READY = 1'b1;
   logic        BUSY, DONE, ABORT, DLY_LD, ERR_CLR, ERR_EN, RES_VALID;
   logic [4:0]  DELAY, RES_TAP;
   logic [15:0] RES_CNT, ERR_CNT;
`ifdef IDELAY_SWEEP_BEST_TAP_EN
   logic [4:0]  BEST_TAP;
   logic [15:0] BEST_CNT;
`endif

   always #5 CLK = ~CLK;

   idelay_sweep_controller #(.WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SET), .CNT_W(16)) dut (
      .CLK(CLK), .RST_N(RST_N), .CAL_RDY(CAL_RDY), .START(START), .BUSY(BUSY),
      .DONE(DONE), .ABORT(ABORT), .DELAY(DELAY), .DLY_LD(DLY_LD), .ERR_CLR(ERR_CLR),
      .ERR_EN(ERR_EN), .ERR_CNT(ERR_CNT), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
      .RES_TAP(RES_TAP), .RES_CNT(RES_CNT)
`ifdef IDELAY_SWEEP_BEST_TAP_EN
      , .BEST_TAP(BEST_TAP), .BEST_CNT(BEST_CNT)
`endif
   );

   typedef struct {
      logic [4:0]  tap;
      logic [15:0] err;
      logic [4:0]  exp_tap;
      logic [15:0] exp_cnt;
   } vec_t;
   vec_t tbl [32];

   // Error counter model: counts ERR_EN cycles, and only in the cycle two after the
   // last enable presents the per-tap count; any other cycle shows 16'hDEAD.
   int en_n;
   int post;
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         en_n    <= 0;
         post    <= 3;
         ERR_CNT <= 16'hDEAD;
      end else begin
         en_n    <= ERR_CLR ? 0 : en_n + (ERR_EN ? 1 : 0);
         post    <= ERR_EN ? 0 : (post < 3 ? post + 1 : 3);
         ERR_CNT <= (en_n == WIN && post == 0) ? tbl[DELAY].err : 16'hDEAD;
      end
   end

   // Event monitor, sampled on the falling edge
   int cyc = 0;
   int n_dly_ld = 0, n_clr = 0, n_en = 0, n_done = 0, n_abort = 0, n_res = 0;
   int start_cyc = 0, done_cyc = 0;
   logic [4:0]  res_tap_log [256];
   logic [15:0] res_cnt_log [256];
   always @(posedge CLK) cyc <= cyc + 1;
   always @(negedge CLK) begin
      if (DLY_LD)  n_dly_ld <= n_dly_ld + 1;
      if (ERR_CLR) n_clr    <= n_clr + 1;
      if (ERR_EN)  n_en     <= n_en + 1;
      if (ABORT)   n_abort  <= n_abort + 1;
      if (DONE) begin
         n_done   <= n_done + 1;
         done_cyc <= cyc;
      end
      if (START && CAL_RDY && !BUSY && RST_N) start_cyc <= cyc;
      if (RES_VALID && RES_READY && CAL_RDY && n_res < 256) begin
         res_tap_log[n_res] <= RES_TAP;
         res_cnt_log[n_res] <= RES_CNT;
         n_res <= n_res + 1;
      end
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic start_pulse();
      START = 1'b1;
      tick();
      START = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      for (int k = 0; k < SWEEP + 100 && !DONE; k++) tick();
      chk(nm, DONE, 1);
   endtask

   int b_res, b_ld, b_clr, b_en, b_done, b_abort;
   logic ok;

   initial begin
      for (int i = 0; i < 32; i++) begin
         tbl[i].tap     = i[4:0];
         tbl[i].err     = (i >= 12 && i <= 14) ? 16'd3 : 16'd100;
         tbl[i].exp_tap = i[4:0];
         tbl[i].exp_cnt = (i >= 12 && i <= 14) ? 16'd3 : 16'd100;
      end

      // Reset state
      repeat (3) tick();
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      chk("rst_abort", ABORT, 0);
      chk("rst_dly_ld", DLY_LD, 0);
      chk("rst_err_en", ERR_EN, 0);
      chk("rst_res_valid", RES_VALID, 0);
      chk("rst_delay", DELAY, 0);
      RST_N = 1'b1;
      tick();

      // START without calibration ready is ignored
      START = 1'b1;
      tick();
      tick();
      chk("nocal_busy", BUSY, 0);
      chk("nocal_dly_ld", DLY_LD, 0);
      START = 1'b0;
      CAL_RDY = 1'b1;
      tick();

      // Full sweep with a redundant START in the middle
      b_res = n_res; b_ld = n_dly_ld; b_clr = n_clr; b_en = n_en; b_done = n_done; b_abort = n_abort;
      start_pulse();
      chk("first_load_delay", DELAY, 0);
      chk("first_load_strobe", DLY_LD, 1);
      repeat (300) tick();
      start_pulse();
      wait_done("sweep_done");
      tick();
      chk("sweep_busy_after", BUSY, 0);
      chk("sweep_len", done_cyc - start_cyc, SWEEP);
      chk("sweep_dly_ld_cnt", n_dly_ld - b_ld, 32);
      chk("sweep_err_clr_cnt", n_clr - b_clr, 32);
      chk("sweep_err_en_cnt", n_en - b_en, 32 * WIN);
      chk("sweep_done_cnt", n_done - b_done, 1);
      chk("sweep_abort_cnt", n_abort - b_abort, 0);
      chk("sweep_res_cnt", n_res - b_res, 32);
      for (int i = 0; i < 32; i++) begin
         chk($sformatf("res_tap[%0d]", i), res_tap_log[b_res + i], tbl[i].exp_tap);
         chk($sformatf("res_cnt[%0d]", i), res_cnt_log[b_res + i], tbl[i].exp_cnt);
      end
`ifdef IDELAY_SWEEP_BEST_TAP_EN
      chk("best_tap", BEST_TAP, 12);
      chk("best_cnt", BEST_CNT, 3);
`endif

      // Back-pressure at tap 5
      b_res = n_res;
      start_pulse();
      for (int k = 0; k < 400 && !(DLY_LD && DELAY == 5); k++) tick();
      chk("bp_reach_tap5", DELAY, 5);
      RES_READY = 1'b0;
      for (int k = 0; k < 100 && !RES_VALID; k++) tick();
      chk("bp_valid", RES_VALID, 1);
      chk("bp_tap", RES_TAP, 5);
      chk("bp_cnt", RES_CNT, 100);
      ok = 1'b1;
      repeat (50) begin
         tick();
         if (!RES_VALID || RES_TAP != 5 || RES_CNT != 100 || DELAY != 5 || DLY_LD) ok = 1'b0;
      end
      chk("bp_hold_stable", ok, 1);
      RES_READY = 1'b1;
      tick();
      chk("bp_next_load", DLY_LD, 1);
      chk("bp_next_delay", DELAY, 6);
      chk("bp_valid_dropped", RES_VALID, 0);
      wait_done("bp_done");
      tick();
      chk("bp_res_cnt", n_res - b_res, 32);
      ok = 1'b1;
      for (int i = 0; i < 32; i++)
         if (res_tap_log[b_res + i] != tbl[i].exp_tap) ok = 1'b0;
      chk("bp_tap_order", ok, 1);

      // Calibration lost during MEASURE of tap 9
      b_done = n_done; b_abort = n_abort;
      start_pulse();
      for (int k = 0; k < 600 && !(DELAY == 9 && ERR_EN); k++) tick();
      chk("ab_reach_meas9", ERR_EN, 1);
      CAL_RDY = 1'b0;
      tick();
      chk("ab_abort", ABORT, 1);
      chk("ab_busy", BUSY, 0);
      chk("ab_err_en", ERR_EN, 0);
      CAL_RDY = 1'b1;
      tick();
      chk("ab_abort_once", ABORT, 0);
      chk("ab_abort_cnt", n_abort - b_abort, 1);
      chk("ab_no_done", n_done - b_done, 0);

      // Restart from tap 0, then abort in REPORT of tap 2 while RES_READY=1
      b_res = n_res;
      start_pulse();
      chk("rs_load", DLY_LD, 1);
      chk("rs_delay", DELAY, 0);
      for (int k = 0; k < 200 && !(RES_VALID && RES_TAP == 2); k++) tick();
      chk("rs_report2", RES_VALID, 1);
      CAL_RDY = 1'b0;
      tick();
      chk("rs_abort", ABORT, 1);
      chk("rs_valid_dropped", RES_VALID, 0);
      chk("rs_no_load", DLY_LD, 0);
      chk("rs_delay_held", DELAY, 2);
      CAL_RDY = 1'b1;
      tick();
      chk("rs_res_discarded", n_res - b_res, 2);

      // Asynchronous reset during SETTLE of tap 3
      b_done = n_done; b_abort = n_abort;
      start_pulse();
      for (int k = 0; k < 200 && !(DLY_LD && DELAY == 3); k++) tick();
      tick();
      chk("rr_in_settle", BUSY, 1);
      #2;
      RST_N = 1'b0;
      #1;
      chk("rr_busy", BUSY, 0);
      chk("rr_delay", DELAY, 0);
      chk("rr_res_tap", RES_TAP, 0);
      chk("rr_res_cnt", RES_CNT, 0);
      chk("rr_flags", {DONE, ABORT, DLY_LD, ERR_CLR, ERR_EN, RES_VALID}, 0);
`ifdef IDELAY_SWEEP_BEST_TAP_EN
      chk("rr_best", {BEST_TAP, BEST_CNT}, 0);
`endif
      repeat (3) tick();
      RST_N = 1'b1;
      repeat (2) tick();
      chk("rr_no_abort", n_abort - b_abort, 0);
      chk("rr_no_done", n_done - b_done, 0);
      chk("rr_idle", BUSY, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
